// File: rtl/cgp_cmp_sweeper.sv
// Exhaustive sweep driver and checker for CGP pair-sum comparators (a+b) > (c+d).
// Define CMP_SWEEP_HIST_EN to build the false-positive / false-negative counters.
module cgp_cmp_sweeper #(
  parameter int W       = 3,
  parameter int DUT_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   input_a,
  output logic [W-1:0]   input_b,
  output logic [W-1:0]   input_c,
  output logic [W-1:0]   input_d,
  input  logic           cgp_out,
  output logic [4*W:0]   err_count,
  output logic [4*W-1:0] first_err_vec,
  output logic           first_err_valid,
  output logic [4*W:0]   fp_count,
  output logic [4*W:0]   fn_count
);

  localparam int VW  = 4 * W;
  localparam int CW  = 4 * W + 1;
  localparam int LCW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

  localparam logic [VW-1:0]  V_ZERO    = {VW{1'b0}};
  localparam logic [VW-1:0]  V_ONE     = VW'(1);
  localparam logic [VW-1:0]  V_LAST    = {VW{1'b1}};
  localparam logic [CW-1:0]  C_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0]  C_ONE     = CW'(1);
  localparam logic [LCW-1:0] L_ZERO    = {LCW{1'b0}};
  localparam logic [LCW-1:0] L_ONE     = LCW'(1);
  localparam logic [LCW-1:0] L_RELOAD  = LCW'(DUT_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [VW-1:0]  vec_r;
  logic [LCW-1:0] drain_cnt_r;
  logic           busy_r;
  logic           done_r;
  logic [CW-1:0]  err_r;
  logic [VW-1:0]  first_vec_r;
  logic           first_valid_r;

  logic           stg0_valid_s;
  logic           stg0_exact_s;
  logic           al_valid_s;
  logic           al_exact_s;
  logic [VW-1:0]  al_vec_s;
  logic           mism_s;
  logic           clear_s;

  // Reference comparison: both pair sums carried at W+1 bits so nothing overflows.
  function automatic logic exact_gt(input logic [VW-1:0] v);
    logic [W:0] sum_ab;
    logic [W:0] sum_cd;
    sum_ab = {1'b0, v[4*W-1:3*W]} + {1'b0, v[3*W-1:2*W]};
    sum_cd = {1'b0, v[2*W-1:W]}   + {1'b0, v[W-1:0]};
    return (sum_ab > sum_cd);
  endfunction

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (vec_r == V_LAST) state_nxt_s = (DUT_LAT == 0) ? ST_DONE : ST_DRAIN;
        else                 state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (drain_cnt_r == L_ZERO) state_nxt_s = ST_DONE;
        else                       state_nxt_s = ST_DRAIN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, vector index, drain counter and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      vec_r       <= V_ZERO;
      drain_cnt_r <= L_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
      done_r  <= (state_nxt_s == ST_DONE);
      // vec_r doubles as the operand register, so it is parked at zero outside RUN.
      if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) vec_r <= vec_r + V_ONE;
      else                                                 vec_r <= V_ZERO;
      if ((state_r == ST_RUN) && (state_nxt_s == ST_DRAIN)) drain_cnt_r <= L_RELOAD;
      else if (state_r == ST_DRAIN)                          drain_cnt_r <= drain_cnt_r - L_ONE;
      else                                                   drain_cnt_r <= drain_cnt_r;
    end
  end

  assign stg0_valid_s = (state_r == ST_RUN);
  assign stg0_exact_s = exact_gt(vec_r);

  generate
    if (DUT_LAT == 0) begin : g_nolat
      assign al_valid_s = stg0_valid_s;
      assign al_exact_s = stg0_exact_s;
      assign al_vec_s   = vec_r;
    end else begin : g_lat
      logic [DUT_LAT-1:0] dl_valid_r;
      logic [DUT_LAT-1:0] dl_exact_r;
      logic [VW-1:0]      dl_vec_r [DUT_LAT];

      // Delay the expected result and its index so they meet cgp_out.
      always_ff @(posedge clk) begin
        if (rst) begin
          dl_valid_r <= {DUT_LAT{1'b0}};
          dl_exact_r <= {DUT_LAT{1'b0}};
          for (int i = 0; i < DUT_LAT; i++) dl_vec_r[i] <= V_ZERO;
        end else begin
          dl_valid_r[0] <= stg0_valid_s;
          dl_exact_r[0] <= stg0_exact_s;
          dl_vec_r[0]   <= vec_r;
          for (int i = 1; i < DUT_LAT; i++) begin
            dl_valid_r[i] <= dl_valid_r[i-1];
            dl_exact_r[i] <= dl_exact_r[i-1];
            dl_vec_r[i]   <= dl_vec_r[i-1];
          end
        end
      end

      assign al_valid_s = dl_valid_r[DUT_LAT-1];
      assign al_exact_s = dl_exact_r[DUT_LAT-1];
      assign al_vec_s   = dl_vec_r[DUT_LAT-1];
    end
  endgenerate

  assign mism_s  = al_valid_s && (cgp_out != al_exact_s);
  assign clear_s = (state_r == ST_IDLE) && start;

  // Mismatch statistics; cleared as a sweep is launched, held afterwards.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      err_r         <= C_ZERO;
      first_vec_r   <= V_ZERO;
      first_valid_r <= 1'b0;
    end else if (mism_s) begin
      err_r <= err_r + C_ONE;
      if (!first_valid_r) begin
        first_vec_r   <= al_vec_s;
        first_valid_r <= 1'b1;
      end else begin
        first_vec_r   <= first_vec_r;
        first_valid_r <= first_valid_r;
      end
    end else begin
      err_r <= err_r;
    end
  end

`ifdef CMP_SWEEP_HIST_EN
  logic [CW-1:0] fp_r;
  logic [CW-1:0] fn_r;

  // Split mismatches by direction: fp when the DUT says 1 but exact is 0.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      fp_r <= C_ZERO;
      fn_r <= C_ZERO;
    end else if (mism_s) begin
      if (cgp_out) fp_r <= fp_r + C_ONE;
      else         fn_r <= fn_r + C_ONE;
    end else begin
      fp_r <= fp_r;
      fn_r <= fn_r;
    end
  end

  assign fp_count = fp_r;
  assign fn_count = fn_r;
`else
  assign fp_count = C_ZERO;
  assign fn_count = C_ZERO;
`endif

  assign busy            = busy_r;
  assign done            = done_r;
  assign input_a         = vec_r[4*W-1:3*W];
  assign input_b         = vec_r[3*W-1:2*W];
  assign input_c         = vec_r[2*W-1:W];
  assign input_d         = vec_r[W-1:0];
  assign err_count       = err_r;
  assign first_err_vec   = first_vec_r;
  assign first_err_valid = first_valid_r;

endmodule

// File: tb/tb_cgp_cmp_sweeper.sv
// Directed bench for cgp_cmp_sweeper: table of full sweeps against modelled
// comparator DUTs (latency 0 and 2), plus start/reset corner sequences.
module tb_cgp_cmp_sweeper;

  localparam int W  = 3;
  localparam int CW = 4 * W + 1;
`ifdef CMP_SWEEP_HIST_EN
  localparam bit HIST_ON = 1'b1;
`else
  localparam bit HIST_ON = 1'b0;
`endif

  typedef struct {
    int mode;       // 0 exact, 1 stuck0, 2 stuck1, 3 inverted, 4 flip at 1234 and 4095
    int sel;        // 0: DUT_LAT=0 instance, 1: DUT_LAT=2 instance (inverted, 2 regs)
    int exp_err;
    int exp_first;
    int exp_fv;
    int exp_fp;
    int exp_fn;
    int exp_done;   // cycle of done, counted as t+N from the start sample
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start1;
  int   mode, sel;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic           busy0, done0, fv0, cgp0;
  logic [W-1:0]   a0, b0, c0, d0;
  logic [CW-1:0]  err0, fp0, fn0;
  logic [4*W-1:0] first0;
  logic           busy1, done1, fv1, cgp1;
  logic [W-1:0]   a1, b1, c1, d1;
  logic [CW-1:0]  err1, fp1, fn1;
  logic [4*W-1:0] first1;
  logic           inv_p1, inv_p2;

  cgp_cmp_sweeper #(.W(W), .DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .input_a(a0), .input_b(b0), .input_c(c0), .input_d(d0), .cgp_out(cgp0),
    .err_count(err0), .first_err_vec(first0), .first_err_valid(fv0),
    .fp_count(fp0), .fn_count(fn0)
  );

  cgp_cmp_sweeper #(.W(W), .DUT_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .input_a(a1), .input_b(b1), .input_c(c1), .input_d(d1), .cgp_out(cgp1),
    .err_count(err1), .first_err_vec(first1), .first_err_valid(fv1),
    .fp_count(fp1), .fn_count(fn1)
  );

  function automatic logic ref_gt(input logic [W-1:0] a, b, c, d);
    logic [W:0] s1, s2;
    s1 = {1'b0, a} + {1'b0, b};
    s2 = {1'b0, c} + {1'b0, d};
    return s1 > s2;
  endfunction

  always_comb begin
    case (mode)
      0: cgp0 = ref_gt(a0, b0, c0, d0);
      1: cgp0 = 1'b0;
      2: cgp0 = 1'b1;
      3: cgp0 = ~ref_gt(a0, b0, c0, d0);
      4: cgp0 = (({a0, b0, c0, d0} == 12'd1234) || ({a0, b0, c0, d0} == 12'd4095))
                ? ~ref_gt(a0, b0, c0, d0) : ref_gt(a0, b0, c0, d0);
      default: cgp0 = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    inv_p1 <= ~ref_gt(a1, b1, c1, d1);
    inv_p2 <= inv_p1;
  end
  assign cgp1 = inv_p2;

  logic           m_busy, m_done, m_fv;
  logic [4*W-1:0] m_ops, m_first;
  logic [CW-1:0]  m_err, m_fp, m_fn;
  always_comb begin
    m_busy  = (sel == 1) ? busy1  : busy0;
    m_done  = (sel == 1) ? done1  : done0;
    m_fv    = (sel == 1) ? fv1    : fv0;
    m_ops   = (sel == 1) ? {a1, b1, c1, d1} : {a0, b0, c0, d0};
    m_first = (sel == 1) ? first1 : first0;
    m_err   = (sel == 1) ? err1   : err0;
    m_fp    = (sel == 1) ? fp1    : fp0;
    m_fn    = (sel == 1) ? fn1    : fn0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  {31'd0, m_busy}, 32'd0);
    check({tag, "_done"},  {31'd0, m_done}, 32'd0);
    check({tag, "_ops"},   {20'd0, m_ops}, 32'd0);
    check({tag, "_err"},   {19'd0, m_err}, 32'd0);
    check({tag, "_first"}, {20'd0, m_first}, 32'd0);
    check({tag, "_fv"},    {31'd0, m_fv}, 32'd0);
    check({tag, "_fp"},    {19'd0, m_fp}, 32'd0);
    check({tag, "_fn"},    {19'd0, m_fn}, 32'd0);
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 1) start1 = 1'b1;
    else            start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic run_sweep(input int idx, input vec_t t);
    int    n;
    string p;
    p    = $sformatf("s%0d", idx);
    mode = t.mode;
    sel  = t.sel;
    pulse_start(t.sel);
    @(negedge clk);
    n = 1;
    check({p, "_busy_rise"}, {31'd0, m_busy}, 32'd1);
    check({p, "_vec0"}, {20'd0, m_ops}, 32'd0);
    while (!m_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({p, "_done_cycle"}, n, t.exp_done);
    check({p, "_busy_at_done"}, {31'd0, m_busy}, 32'd0);
    check({p, "_err"},   {19'd0, m_err}, t.exp_err);
    check({p, "_first"}, {20'd0, m_first}, t.exp_first);
    check({p, "_fv"},    {31'd0, m_fv}, t.exp_fv);
    check({p, "_fp"},    {19'd0, m_fp}, HIST_ON ? t.exp_fp : 0);
    check({p, "_fn"},    {19'd0, m_fn}, HIST_ON ? t.exp_fn : 0);
    // start while in DONE must be ignored
    if (t.sel == 1) start1 = 1'b1;
    else            start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    check({p, "_done_pulse"}, {31'd0, m_done}, 32'd0);
    check({p, "_start_in_done"}, {31'd0, m_busy}, 32'd0);
    check({p, "_err_hold"}, {19'd0, m_err}, t.exp_err);
  endtask

  vec_t tbl[6];

  initial begin
    int n_done;
    tbl[0] = '{mode: 2, sel: 0, exp_err: 2220, exp_first: 0,    exp_fv: 1, exp_fp: 2220, exp_fn: 0,    exp_done: 4097};
    tbl[1] = '{mode: 0, sel: 0, exp_err: 0,    exp_first: 0,    exp_fv: 0, exp_fp: 0,    exp_fn: 0,    exp_done: 4097};
    tbl[2] = '{mode: 1, sel: 0, exp_err: 1876, exp_first: 64,   exp_fv: 1, exp_fp: 0,    exp_fn: 1876, exp_done: 4097};
    tbl[3] = '{mode: 3, sel: 0, exp_err: 4096, exp_first: 0,    exp_fv: 1, exp_fp: 2220, exp_fn: 1876, exp_done: 4097};
    tbl[4] = '{mode: 4, sel: 0, exp_err: 2,    exp_first: 1234, exp_fv: 1, exp_fp: 1,    exp_fn: 1,    exp_done: 4097};
    tbl[5] = '{mode: 3, sel: 1, exp_err: 4096, exp_first: 0,    exp_fv: 1, exp_fp: 2220, exp_fn: 1876, exp_done: 4099};

    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    sel    = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("rst0");
    sel = 1;
    check_idle_zero("rst1");

    for (int i = 0; i < 6; i++) run_sweep(i, tbl[i]);

    // Second start mid-sweep is ignored; reset mid-sweep aborts without done.
    sel  = 0;
    mode = 1;
    pulse_start(0);
    @(negedge clk);
    repeat (100) @(negedge clk);
    check("mid_vec100", {20'd0, m_ops}, 32'd100);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    @(negedge clk);
    check("restart_ignored_vec", {20'd0, m_ops}, 32'd101);
    check("restart_ignored_busy", {31'd0, m_busy}, 32'd1);
    repeat (1899) @(negedge clk);
    check("mid_vec2000", {20'd0, m_ops}, 32'd2000);
    check("mid_err_nonzero", {31'd0, (m_err != 13'd0)}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("abort");
    n_done = 0;
    repeat (4200) begin
      @(negedge clk);
      if (m_done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_idle_busy", {31'd0, m_busy}, 32'd0);
    run_sweep(6, tbl[2]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
